// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC zone scheduler.
// The optional HVAC_CONFLICT_FAULT_EN build uses the same types.
package hvac_pkg;

    localparam int DWELL_DEFAULT    = 8;
    localparam int DEADTIME_DEFAULT = 4;
    localparam int CNT_W            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_HEAT = 1'b0,
        MODE_COOL = 1'b1
    } mode_t;

    // Increment that sticks at lim; used for the dwell counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/hvac_zone_scheduler_if.sv
// Request/plant-control bundle between the zone controllers and the scheduler.
// The fault vector exists only when HVAC_CONFLICT_FAULT_EN is defined.
interface hvac_zone_scheduler_if #(
    parameter int NZONES = 4
);
    localparam int ZW = $clog2(NZONES);

    logic [NZONES-1:0] heat_req;
    logic [NZONES-1:0] cool_req;
    logic              heating;
    logic              cooling;
    logic [NZONES-1:0] valve;
    logic [ZW-1:0]     zone;
    logic              busy;
`ifdef HVAC_CONFLICT_FAULT_EN
    logic [NZONES-1:0] fault;
`endif

    modport master (
        output heat_req, cool_req,
        input  heating, cooling, valve, zone, busy
`ifdef HVAC_CONFLICT_FAULT_EN
        , input fault
`endif
    );

    modport slave (
        input  heat_req, cool_req,
        output heating, cooling, valve, zone, busy
`ifdef HVAC_CONFLICT_FAULT_EN
        , output fault
`endif
    );

endinterface

// File: rtl/hvac_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last',
// wrapping modulo N. Shared by other single-resource arbiters.
module hvac_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] cand_idx [N];
    logic [N-1:0] cand_hit;

    // Candidate gi is the zone gi+1 places after 'last'.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum = {1'b0, last} + (W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
            assign cand_hit[gi] = eligible[cand_idx[gi]];
        end
    endgenerate

    assign found = |cand_hit;

    always_comb begin
        index = last;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Round-robin plant scheduler with minimum dwell and all-off dead time.
// Define HVAC_CONFLICT_FAULT_EN to flag and exclude zones requesting heat and cool at once.
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int NZONES   = 4,
    parameter int DWELL    = DWELL_DEFAULT,
    parameter int DEADTIME = DEADTIME_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    hvac_zone_scheduler_if.slave  bus
);

    localparam int ZW = $clog2(NZONES);
    localparam logic [ZW-1:0]    LAST_ZONE = ZW'(NZONES - 1);
    localparam logic [CNT_W-1:0] DWELL_C   = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEADTIME);

    state_t            state_reg;
    mode_t             mode_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ZW-1:0]     zone_reg;
    logic [NZONES-1:0] valve_reg;
    logic              heating_reg;
    logic              cooling_reg;
    logic              busy_reg;

    logic [NZONES-1:0] eligible;
    logic              own_req;
    logic [NZONES-1:0] others_vec;
    logic              any_other;
    logic              pick_found;
    logic [ZW-1:0]     pick_idx;
    logic [NZONES-1:0] pick_oh;
    logic              pick_heat;

`ifdef HVAC_CONFLICT_FAULT_EN
    logic [NZONES-1:0] conflict;
    logic [NZONES-1:0] fault_reg;

    assign conflict = bus.heat_req & bus.cool_req;
    assign eligible = (bus.heat_req | bus.cool_req) & ~conflict;
    // A conflicting served zone counts as having dropped its request.
    assign own_req  = ((mode_reg == MODE_HEAT) ? bus.heat_req[zone_reg]
                                               : bus.cool_req[zone_reg])
                      & ~conflict[zone_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= '0;
        end else begin
            fault_reg <= conflict;
        end
    end

    assign bus.fault = fault_reg;
`else
    assign eligible = bus.heat_req | bus.cool_req;
    assign own_req  = (mode_reg == MODE_HEAT) ? bus.heat_req[zone_reg]
                                              : bus.cool_req[zone_reg];
`endif

    generate
        for (genvar gi = 0; gi < NZONES; gi++) begin : g_zone
            assign others_vec[gi] = eligible[gi] && (zone_reg != ZW'(gi));
            assign pick_oh[gi]    = (pick_idx == ZW'(gi));
        end
    endgenerate

    assign any_other = |others_vec;
    assign pick_heat = bus.heat_req[pick_idx];

    hvac_rr_pick #(
        .N (NZONES),
        .W (ZW)
    ) u_pick (
        .eligible (eligible),
        .last     (zone_reg),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mode_reg    <= MODE_HEAT;
            cnt_reg     <= '0;
            zone_reg    <= LAST_ZONE;
            valve_reg   <= '0;
            heating_reg <= 1'b0;
            cooling_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg   <= SERVE;
                        zone_reg    <= pick_idx;
                        mode_reg    <= pick_heat ? MODE_HEAT : MODE_COOL;
                        cnt_reg     <= CNT_W'(1);
                        valve_reg   <= pick_oh;
                        heating_reg <= pick_heat;
                        cooling_reg <= !pick_heat;
                        busy_reg    <= 1'b1;
                    end
                end
                SERVE: begin
                    // Release is only considered once the dwell has been met.
                    if (cnt_reg == DWELL_C && (!own_req || any_other)) begin
                        state_reg   <= DEAD;
                        valve_reg   <= '0;
                        heating_reg <= 1'b0;
                        cooling_reg <= 1'b0;
                        cnt_reg     <= CNT_W'(1);
                    end else begin
                        cnt_reg <= sat_inc(cnt_reg, DWELL_C);
                    end
                end
                DEAD: begin
                    if (cnt_reg == DEAD_C) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.heating = heating_reg;
    assign bus.cooling = cooling_reg;
    assign bus.valve   = valve_reg;
    assign bus.zone    = zone_reg;
    assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Self-checking bench for hvac_zone_scheduler (4 zones, dwell 8, dead time 4).
// Covers HVAC_CONFLICT_FAULT_EN builds as well as the default build.
module tb_hvac_zone_scheduler;

    localparam int NZ       = 4;
    localparam int DWELL    = 8;
    localparam int DEADTIME = 4;

    logic clk = 1'b0;
    logic rst;

    int total  = 0;
    int passed = 0;

    hvac_zone_scheduler_if #(.NZONES(NZ)) bus ();

    hvac_zone_scheduler #(
        .NZONES   (NZ),
        .DWELL    (DWELL),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: a grant record plus remaining dead cycles and the last winner.
    bit       m_serving;
    int       m_zone;
    bit       m_heat;
    int       m_on;
    int       m_dead;
    int       m_last;
    bit [3:0] m_fault;

    task automatic model_step(input logic r, input logic [3:0] h, input logic [3:0] c);
        logic [3:0] conf;
        logic [3:0] elig;
        bit         own;
        bit         other;
        bit         got;
        int         cand;
        conf = h & c;
`ifdef HVAC_CONFLICT_FAULT_EN
        elig = (h | c) & ~conf;
`else
        elig = h | c;
`endif
        if (r) begin
            m_serving = 0;
            m_dead    = 0;
            m_on      = 0;
            m_last    = NZ - 1;
            m_zone    = NZ - 1;
            m_heat    = 0;
            m_fault   = '0;
        end else begin
            m_fault = conf;
            if (m_serving) begin
                own = m_heat ? h[m_zone] : c[m_zone];
`ifdef HVAC_CONFLICT_FAULT_EN
                if (conf[m_zone]) own = 0;
`endif
                other = 0;
                for (int i = 0; i < NZ; i++) begin
                    if (i != m_zone && elig[i]) other = 1;
                end
                if (m_on >= DWELL && (!own || other)) begin
                    m_serving = 0;
                    m_dead    = DEADTIME;
                end else begin
                    m_on++;
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else begin
                got = 0;
                for (int k = 1; k <= NZ; k++) begin
                    cand = (m_last + k) % NZ;
                    if (!got && elig[cand]) begin
                        got       = 1;
                        m_serving = 1;
                        m_zone    = cand;
                        m_last    = cand;
                        m_heat    = h[cand];
                        m_on      = 1;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare, one time unit after every rising edge.
    initial begin
        logic [3:0] exp_valve;
        forever begin
            @(posedge clk);
            model_step(rst, bus.heat_req, bus.cool_req);
            #1;
            exp_valve = m_serving ? 4'(1 << m_zone) : 4'b0000;
            check("valve",   32'(bus.valve),   32'(exp_valve));
            check("heating", 32'(bus.heating), 32'(m_serving && m_heat));
            check("cooling", 32'(bus.cooling), 32'(m_serving && !m_heat));
            check("zone",    32'(bus.zone),    32'(m_last));
            check("busy",    32'(bus.busy),    32'(m_serving || m_dead > 0));
            check("excl",    32'(bus.heating & bus.cooling), 32'd0);
`ifdef HVAC_CONFLICT_FAULT_EN
            check("fault",   32'(bus.fault),   32'(m_fault));
`endif
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n_cool;
        int n_dead;
        int n_grants;
        int g_zone [3];
        int g_heat [3];
        int run_len;
        int first_run;
        int z1_seen;
        int z3_heat;
        logic [3:0] prev_valve;

        rst          = 1'b1;
        bus.heat_req = '0;
        bus.cool_req = '0;
        wait_neg(2);
        rst = 1'b0;

        // Idle after reset
        wait_neg(20);
        check("idle_busy",  32'(bus.busy),  32'd0);
        check("idle_valve", 32'(bus.valve), 32'd0);
        check("idle_zone",  32'(bus.zone),  32'd3);
        $display("txn idle: zone=%0d busy=%0b", bus.zone, bus.busy);

        // Single heat requester on zone 2, held
        bus.heat_req = 4'b0100;
        wait_neg(1);
        check("hold_valve0",  32'(bus.valve),   32'h4);
        check("hold_heating", 32'(bus.heating), 32'd1);
        check("hold_zone",    32'(bus.zone),    32'd2);
        wait_neg(30);
        check("hold_valve30", 32'(bus.valve),   32'h4);
        bus.heat_req = 4'b0000;
        wait_neg(1);
        check("drop_valve", 32'(bus.valve), 32'd0);
        check("drop_busy",  32'(bus.busy),  32'd1);
        $display("txn hold zone2 heat: released after drop");
        wait_neg(6);

        // One-cycle cool pulse on zone 1: dwell then dead time
        bus.cool_req = 4'b0010;
        wait_neg(1);
        bus.cool_req = 4'b0000;
        check("pulse_zone", 32'(bus.zone), 32'd1);
        n_cool = 0;
        n_dead = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cooling && bus.valve == 4'b0010) n_cool++;
            else if (bus.busy) n_dead++;
            wait_neg(1);
        end
        check("pulse_on_cycles",   32'(n_cool), 32'd8);
        check("pulse_dead_cycles", 32'(n_dead), 32'd4);
        $display("txn pulse zone1 cool: on=%0d dead=%0d", n_cool, n_dead);

        // Two competing zones alternate
        bus.heat_req = 4'b0001;
        bus.cool_req = 4'b1000;
        n_grants   = 0;
        run_len    = 0;
        first_run  = 0;
        prev_valve = '0;
        for (int i = 0; i < 60; i++) begin
            wait_neg(1);
            if (bus.valve != 4'b0000 && prev_valve == 4'b0000 && n_grants < 3) begin
                g_zone[n_grants] = int'(bus.zone);
                g_heat[n_grants] = int'(bus.heating);
                n_grants++;
            end
            if (n_grants == 1 && bus.valve != 4'b0000) run_len++;
            if (n_grants == 1 && bus.valve == 4'b0000 && first_run == 0) first_run = run_len;
            prev_valve = bus.valve;
        end
        check("alt_grants", 32'(n_grants), 32'd3);
        if (n_grants == 3) begin
            check("alt_g0_zone", 32'(g_zone[0]), 32'd3);
            check("alt_g0_heat", 32'(g_heat[0]), 32'd0);
            check("alt_g1_zone", 32'(g_zone[1]), 32'd0);
            check("alt_g1_heat", 32'(g_heat[1]), 32'd1);
            check("alt_g2_zone", 32'(g_zone[2]), 32'd3);
        end
        check("alt_run_len", 32'(first_run), 32'd8);
        $display("txn alternate: grants=%0d first_run=%0d", n_grants, first_run);
        bus.heat_req = '0;
        bus.cool_req = '0;
        wait_neg(20);

        // Reset during the third serve cycle
        bus.heat_req = 4'b0100;
        wait_neg(3);
        rst = 1'b1;
        wait_neg(1);
        check("rst_valve", 32'(bus.valve),   32'd0);
        check("rst_zone",  32'(bus.zone),    32'd3);
        check("rst_busy",  32'(bus.busy),    32'd0);
        check("rst_heat",  32'(bus.heating), 32'd0);
        rst          = 1'b0;
        bus.heat_req = 4'b0101;
        wait_neg(1);
        check("regrant_zone",  32'(bus.zone),  32'd0);
        check("regrant_valve", 32'(bus.valve), 32'h1);
        $display("txn reset mid-serve: regrant zone=%0d", bus.zone);
        bus.heat_req = '0;
        wait_neg(20);

        // Same zone requesting heat and cool
`ifdef HVAC_CONFLICT_FAULT_EN
        bus.heat_req = 4'b1010;
        bus.cool_req = 4'b0010;
        wait_neg(1);
        check("conf_fault", 32'(bus.fault),   32'h2);
        check("conf_valve", 32'(bus.valve),   32'h8);
        check("conf_heat",  32'(bus.heating), 32'd1);
        z1_seen = 0;
        z3_heat = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.valve[1]) z1_seen++;
            if (bus.valve == 4'b1000 && bus.heating) z3_heat++;
            wait_neg(1);
        end
        check("conf_zone1_never", 32'(z1_seen), 32'd0);
        check("conf_zone3_held",  32'(z3_heat), 32'd30);
`else
        bus.heat_req = 4'b0010;
        bus.cool_req = 4'b0010;
        wait_neg(1);
        check("both_valve", 32'(bus.valve),   32'h2);
        check("both_heat",  32'(bus.heating), 32'd1);
        z1_seen = 0;
        z3_heat = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.cooling) z1_seen++;
            if (bus.valve == 4'b0010 && bus.heating) z3_heat++;
            wait_neg(1);
        end
        check("both_never_cool", 32'(z1_seen), 32'd0);
        check("both_heat_held",  32'(z3_heat), 32'd30);
`endif
        $display("txn conflict: valve=%b heating=%0b", bus.valve, bus.heating);
        bus.heat_req = '0;
        bus.cool_req = '0;
        wait_neg(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
